// File: rtl/alu_result_collector.sv
// alu_result_collector: tags each completed ALU unit result with its source
// unit, buffers it in a small FIFO, and presents the head entry to a consumer
// over a valid/ready handshake. Sticky error bits record dropped results and
// cycles in which more than one unit flagged a result.
//
// Handshake: out_valid is high whenever the FIFO holds at least one entry.
// out_data/out_src/out_carry describe the head entry and hold stable while
// out_valid is high and out_ready is low. An entry is consumed on a rising
// CLK edge where out_valid and out_ready are both high. out_ready while empty
// has no effect.
module alu_result_collector #(
    parameter int out_width     = 16,
    parameter int CMP_out_width = 2,
    parameter int DEPTH         = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [out_width-1:0]       arith_out,
    input  logic [out_width-1:0]       logic_out,
    input  logic [out_width-1:0]       shift_out,
    input  logic [CMP_out_width-1:0]   CMP_out,
    input  logic                       arith_flag,
    input  logic                       logic_flag,
    input  logic                       CMP_flag,
    input  logic                       shift_flag,
    input  logic                       carry_out,
    input  logic                       out_ready,
    input  logic                       clr_err,
    output logic                       out_valid,
    output logic [out_width-1:0]       out_data,
    output logic [1:0]                 out_src,
    output logic                       out_carry,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow_err,
    output logic                       multi_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Entry layout: {src[1:0], carry, data}
    localparam int ENT_W = out_width + 3;

    localparam logic [1:0] SRC_ARITH = 2'b00;
    localparam logic [1:0] SRC_LOGIC = 2'b01;
    localparam logic [1:0] SRC_CMP   = 2'b10;
    localparam logic [1:0] SRC_SHIFT = 2'b11;

    logic [ENT_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [1:0]           cap_src;
    logic [out_width-1:0] cap_data;
    logic                 cap_carry;
    logic [2:0]           flag_sum;
    logic                 any_flag;
    logic                 multi_flag;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [ENT_W-1:0]     head;

    // Select the highest-priority flagged unit: arith > logic > CMP > shift
    always_comb begin
        cap_src   = SRC_ARITH;
        cap_data  = '0;
        cap_carry = 1'b0;
        if (arith_flag) begin
            cap_src   = SRC_ARITH;
            cap_data  = arith_out;
            cap_carry = carry_out;
        end else if (logic_flag) begin
            cap_src   = SRC_LOGIC;
            cap_data  = logic_out;
        end else if (CMP_flag) begin
            cap_src   = SRC_CMP;
            cap_data  = {{(out_width-CMP_out_width){1'b0}}, CMP_out};
        end else if (shift_flag) begin
            cap_src   = SRC_SHIFT;
            cap_data  = shift_out;
        end
    end

    // Push/pop qualification; a full FIFO still accepts a push when it pops
    always_comb begin
        flag_sum   = 3'(arith_flag) + 3'(logic_flag) + 3'(CMP_flag) + 3'(shift_flag);
        any_flag   = (flag_sum != 3'd0);
        multi_flag = (flag_sum > 3'd1);
        full       = (count == CNT_W'(DEPTH));
        pop        = out_valid & out_ready;
        push       = any_flag & (~full | pop);
        drop       = any_flag & full & ~pop;
    end

    // All state: storage, pointers, occupancy and sticky error bits
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            multi_err    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {cap_src, cap_carry, cap_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // A new error event in the clearing cycle wins over clr_err
            overflow_err <= (overflow_err & ~clr_err) | drop;
            multi_err    <= (multi_err & ~clr_err) | multi_flag;
        end
    end

    // Head entry presentation, driven purely from registered state
    always_comb begin
        head       = mem[rd_ptr];
        out_valid  = (count != '0);
        fifo_count = count;
        out_data   = out_valid ? head[out_width-1:0] : '0;
        out_carry  = out_valid ? head[out_width]     : 1'b0;
        out_src    = out_valid ? head[ENT_W-1 -: 2]  : 2'b00;
    end

endmodule
